// File: rtl/rst_sequencer.sv
// -----------------------------------------------------------------------------
// rst_sequencer
//
// Purpose:
//   Releases the Wishbone-side reset domains in index order once the clock
//   source has been locked for LOCK_FILTER consecutive cycles. Releases are
//   spaced STAGE_CYCLES apart. Once every domain is running, per-domain
//   software soft-reset requests are serviced one at a time. The lowest
//   pending index wins. Any loss of lock puts every domain back into reset
//   and restarts the whole sequence.
//
// Parameters:
//   NUM_DOMAINS  (1..16) number of sequenced reset domains
//   LOCK_FILTER  (>=1)   consecutive locked=1 samples needed before release
//   STAGE_CYCLES (>=1)   spacing between releases; also soft-reset hold time
//
// Ports:
//   wb_clk      in   system clock; everything runs on its rising edge
//   wb_rst_n    in   asynchronous active-low reset
//   locked      in   clock-source lock, synchronous to wb_clk
//   sw_rst_req  in   [NUM_DOMAINS] one-cycle soft-reset request pulses
//   dom_rst     out  [NUM_DOMAINS] active-high reset per domain (registered)
//   seq_done    out  all domains released and no soft reset in progress
//   sw_rst_ack  out  [NUM_DOMAINS] one-cycle pulse when a soft reset completes
//
// Build option:
//   RST_SEQ_SOFT_RST_EN - when defined, compiles in the pending register, the
//   arbiter and the SOFT state. When it is not defined, sw_rst_req is ignored
//   and sw_rst_ack stays 0. In that case RUN is left only on loss of lock.
// -----------------------------------------------------------------------------
module rst_sequencer #(
  parameter int NUM_DOMAINS  = 4,
  parameter int LOCK_FILTER  = 16,
  parameter int STAGE_CYCLES = 16
) (
  input  logic                   wb_clk,
  input  logic                   wb_rst_n,
  input  logic                   locked,
  input  logic [NUM_DOMAINS-1:0] sw_rst_req,
  output logic [NUM_DOMAINS-1:0] dom_rst,
  output logic                   seq_done,
  output logic [NUM_DOMAINS-1:0] sw_rst_ack
);

  localparam int LCW = (LOCK_FILTER  > 1) ? $clog2(LOCK_FILTER)  : 1;
  localparam int SCW = (STAGE_CYCLES > 1) ? $clog2(STAGE_CYCLES) : 1;
  localparam int IW  = (NUM_DOMAINS  > 1) ? $clog2(NUM_DOMAINS)  : 1;

  localparam logic [LCW-1:0] LC_LAST  = LCW'(LOCK_FILTER - 1);
  localparam logic [SCW-1:0] ST_LAST  = SCW'(STAGE_CYCLES - 1);
  localparam logic [IW-1:0]  IDX_LAST = IW'(NUM_DOMAINS - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    RELEASE   = 2'd1,
    RUN       = 2'd2,
    SOFT      = 2'd3
  } state_t;

  state_t         state_reg;
  logic [LCW-1:0] lock_cnt_reg;
  logic [SCW-1:0] stage_cnt_reg;
  logic [IW-1:0]  idx_reg;

`ifdef RST_SEQ_SOFT_RST_EN
  logic [NUM_DOMAINS-1:0] pending_reg;
  // One-hot mask of the domain currently held in soft reset.
  logic [NUM_DOMAINS-1:0] soft_mask_reg;
  logic [NUM_DOMAINS-1:0] grant_oh;

  // Isolate the lowest set bit of pending: x & (-x) in two's complement.
  assign grant_oh = pending_reg & ((~pending_reg) + NUM_DOMAINS'(1));
`else
  // Soft-reset requests have no effect in this build.
  logic unused_sw_rst_req;
  assign unused_sw_rst_req = ^sw_rst_req;
`endif

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_reg     <= WAIT_LOCK;
      lock_cnt_reg  <= '0;
      stage_cnt_reg <= '0;
      idx_reg       <= '0;
      dom_rst       <= '1;
      seq_done      <= 1'b0;
      sw_rst_ack    <= '0;
`ifdef RST_SEQ_SOFT_RST_EN
      pending_reg   <= '0;
      soft_mask_reg <= '0;
`endif
    end else begin
      // The acknowledge is a single-cycle pulse.
      sw_rst_ack <= '0;

      if (state_reg != WAIT_LOCK && !locked) begin
        // Lock lost: put everything back into reset and drop queued work.
        // An in-flight soft reset is abandoned without an acknowledge.
        state_reg     <= WAIT_LOCK;
        lock_cnt_reg  <= '0;
        stage_cnt_reg <= '0;
        idx_reg       <= '0;
        dom_rst       <= '1;
        seq_done      <= 1'b0;
`ifdef RST_SEQ_SOFT_RST_EN
        pending_reg   <= '0;
        soft_mask_reg <= '0;
`endif
      end else begin
        case (state_reg)
          WAIT_LOCK: begin
            dom_rst  <= '1;
            seq_done <= 1'b0;
            if (!locked) begin
              lock_cnt_reg <= '0;
            end else if (lock_cnt_reg == LC_LAST) begin
              // This is the LOCK_FILTER-th consecutive locked sample.
              state_reg     <= RELEASE;
              lock_cnt_reg  <= '0;
              stage_cnt_reg <= '0;
              idx_reg       <= '0;
            end else begin
              lock_cnt_reg <= lock_cnt_reg + LCW'(1);
            end
          end

          RELEASE: begin
            if (stage_cnt_reg == ST_LAST) begin
              dom_rst[idx_reg] <= 1'b0;
              stage_cnt_reg    <= '0;
              if (idx_reg == IDX_LAST) begin
                state_reg <= RUN;
                seq_done  <= 1'b1;
              end else begin
                idx_reg <= idx_reg + IW'(1);
              end
            end else begin
              stage_cnt_reg <= stage_cnt_reg + SCW'(1);
            end
          end

`ifdef RST_SEQ_SOFT_RST_EN
          RUN: begin
            if (pending_reg != '0) begin
              // Grant the lowest pending domain. A new request for the same
              // domain on this edge is queued again, not lost.
              pending_reg   <= (pending_reg & ~grant_oh) | sw_rst_req;
              soft_mask_reg <= grant_oh;
              dom_rst       <= dom_rst | grant_oh;
              seq_done      <= 1'b0;
              stage_cnt_reg <= '0;
              state_reg     <= SOFT;
            end else begin
              pending_reg <= sw_rst_req;
            end
          end

          SOFT: begin
            pending_reg <= pending_reg | sw_rst_req;
            if (stage_cnt_reg == ST_LAST) begin
              dom_rst       <= dom_rst & ~soft_mask_reg;
              sw_rst_ack    <= soft_mask_reg;
              soft_mask_reg <= '0;
              stage_cnt_reg <= '0;
              state_reg     <= RUN;
              // Queued work keeps seq_done low. The next grant follows on
              // the next edge, so there is no one-cycle done glitch.
              seq_done      <= (pending_reg == '0);
            end else begin
              stage_cnt_reg <= stage_cnt_reg + SCW'(1);
            end
          end
`endif

          default: begin
            // RUN with soft reset compiled out: hold until lock is lost.
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rst_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rst_sequencer
//
// Purpose:
//   Drives directed and random lock/request stimulus into rst_sequencer.
//   For every clock edge the stimulus process computes the expected outputs
//   with a timeline-level reference model and queues them. A separate monitor
//   process pops each entry after the edge and compares it with the DUT
//   outputs.
//
// Reference model:
//   The model counts consecutive locked samples. Domain i is out of reset
//   once that count reaches LF + S*(i+1). Soft resets are modelled as jobs
//   with an absolute end edge. It follows whichever build is selected by
//   RST_SEQ_SOFT_RST_EN.
// -----------------------------------------------------------------------------
module tb_rst_sequencer;

  localparam int N     = 4;
  localparam int LF    = 16;
  localparam int S     = 16;
  localparam int T_RUN = LF + S * N;

`ifdef RST_SEQ_SOFT_RST_EN
  localparam bit SOFT_EN = 1'b1;
`else
  localparam bit SOFT_EN = 1'b0;
`endif

  logic         wb_clk = 1'b1;
  logic         wb_rst_n = 1'b0;
  logic         locked = 1'b0;
  logic [N-1:0] sw_rst_req = '0;
  logic [N-1:0] dom_rst;
  logic         seq_done;
  logic [N-1:0] sw_rst_ack;

  rst_sequencer #(
    .NUM_DOMAINS (N),
    .LOCK_FILTER (LF),
    .STAGE_CYCLES(S)
  ) dut (
    .wb_clk    (wb_clk),
    .wb_rst_n  (wb_rst_n),
    .locked    (locked),
    .sw_rst_req(sw_rst_req),
    .dom_rst   (dom_rst),
    .seq_done  (seq_done),
    .sw_rst_ack(sw_rst_ack)
  );

  always #5 wb_clk = ~wb_clk;

  typedef struct {
    int           edge_n;
    logic [N-1:0] dom;
    logic         done;
    logic [N-1:0] ack;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int           consec    = 0;   // consecutive locked=1 samples
  int           edge_n    = 0;   // edges since reset release
  int           cur       = -1;  // domain in soft reset, -1 when idle
  int           job_end   = 0;   // edge on which the current job completes
  logic [N-1:0] m_pending = '0;
  logic         prev_rst  = 1'b0;

  task automatic model_step(input logic rst_v, input logic lk,
                            input logic [N-1:0] rq, output exp_t e);
    logic [N-1:0] pend_before;
    bit           run_before;
    int           g;
    e.ack = '0;
    if (!rst_v) begin
      consec    = 0;
      edge_n    = 0;
      cur       = -1;
      m_pending = '0;
      e.edge_n  = 0;
      e.dom     = '1;
      e.done    = 1'b0;
    end else begin
      edge_n++;
      pend_before = m_pending;
      if (!lk) begin
        consec    = 0;
        cur       = -1;
        m_pending = '0;
      end else begin
        run_before = (consec >= T_RUN);
        consec++;
        if (SOFT_EN && run_before) begin
          if (cur >= 0) begin
            if (edge_n == job_end) begin
              e.ack[cur] = 1'b1;
              cur = -1;
            end
          end else if (pend_before != '0) begin
            g = 0;
            for (int i = N - 1; i >= 0; i--) if (pend_before[i]) g = i;
            m_pending[g] = 1'b0;
            cur     = g;
            job_end = edge_n + S;
          end
          m_pending = m_pending | rq;
        end
      end
      e.edge_n = edge_n;
      for (int i = 0; i < N; i++) e.dom[i] = (consec < LF + S * (i + 1));
      if (cur >= 0) e.dom[cur] = 1'b1;
      e.done = (consec >= T_RUN) && (cur < 0) && (pend_before == '0);
    end
  endtask

  // Apply one cycle of stimulus and queue the expected outputs after the edge.
  task automatic do_cycle(input logic rst_v, input logic lk, input logic [N-1:0] rq);
    exp_t e;
    @(negedge wb_clk);
    wb_rst_n   = rst_v;
    locked     = lk;
    sw_rst_req = rq;
    if (!rst_v && prev_rst) begin
      // Reset assertion must act before the next clock edge.
      #2;
      n_checks++;
      if (dom_rst !== '1 || seq_done !== 1'b0 || sw_rst_ack !== '0) begin
        n_fail++;
        $display("FAIL async_reset: dom_rst=%b seq_done=%b ack=%b, required dom_rst=%b seq_done=0 ack=%b",
                 dom_rst, seq_done, sw_rst_ack, {N{1'b1}}, {N{1'b0}});
      end
    end
    prev_rst = rst_v;
    model_step(rst_v, lk, rq, e);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) do_cycle(1'b1, 1'b1, '0);
  endtask

  // Monitor: compare DUT outputs against the queued expectation after every edge.
  initial begin : monitor
    exp_t            e;
    logic [2*N:0]    prev_out;
    prev_out = 'x;
    forever begin
      @(posedge wb_clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (dom_rst !== e.dom || seq_done !== e.done || sw_rst_ack !== e.ack) begin
          n_fail++;
          $display("FAIL outputs edge %0d: dom_rst=%b seq_done=%b ack=%b, required dom_rst=%b seq_done=%b ack=%b",
                   e.edge_n, dom_rst, seq_done, sw_rst_ack, e.dom, e.done, e.ack);
        end else if ({dom_rst, seq_done, sw_rst_ack} !== prev_out) begin
          $display("edge %0d: dom_rst=%b seq_done=%b ack=%b",
                   e.edge_n, dom_rst, seq_done, sw_rst_ack);
        end
        prev_out = {dom_rst, seq_done, sw_rst_ack};
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [N-1:0] rq;
    logic         lk;
    logic         rv;

    // Power-up: 3 reset cycles, then locked from edge 1
    for (int k = 0; k < 3; k++) do_cycle(1'b0, 1'b1, '0);
    idle(100);

    // Lock glitch in WAIT_LOCK (locked=0 sampled at edge 11)
    for (int k = 0; k < 2; k++) do_cycle(1'b0, 1'b1, '0);
    idle(10);
    do_cycle(1'b1, 1'b0, '0);
    idle(95);

    // Lock loss in RUN, then a full re-sequence
    do_cycle(1'b1, 1'b0, '0);
    idle(100);

    // Soft-reset patterns
    do_cycle(1'b1, 1'b1, 4'b0100);
    idle(20);
    do_cycle(1'b1, 1'b1, 4'b1010);
    idle(40);
    do_cycle(1'b1, 1'b1, 4'b1111);
    idle(75);
    do_cycle(1'b1, 1'b1, 4'b0001);
    idle(5);
    do_cycle(1'b1, 1'b1, 4'b0001);  // repeat request for the domain in service
    idle(40);

    // Lock loss during a soft reset: aborted, no acknowledge
    do_cycle(1'b1, 1'b1, 4'b0010);
    idle(5);
    do_cycle(1'b1, 1'b0, '0);
    idle(100);

    // Random traffic with rare lock drops and occasional resets
    for (int k = 0; k < 4000; k++) begin
      lk = ($urandom_range(0, 299) != 0);
      rq = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
      rv = ($urandom_range(0, 1999) != 0);
      do_cycle(rv, lk, rq);
    end
    idle(5);

    @(posedge wb_clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
